// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: default widths, FSM state
// encoding, table size and the flat code-region address map.
package instr_pkg;

  localparam int D_DEF       = 12;
  localparam int B_DEF       = 5;
  localparam int TABLE_WORDS = 1 << B_DEF;

  typedef enum logic [2:0] {
    IDLE,
    TABLE,
    CODE,
    CHECK,
    FINISH
  } state_t;

  // Code words sit directly above the branch table in the flat map.
  function automatic int unsigned code_addr(input int unsigned j, input int unsigned b);
    return (32'd1 << b) + j;
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Word-stream handshake plus memory write port of the instruction loader.
// master = loader side, slave = source/memory side.
interface instr_loader_if
  import instr_pkg::*;
#(
  parameter int D = D_DEF
);
  logic [8:0] in_word;
  logic       in_valid;
  logic       in_ready;
  logic       wr_en;
  logic [D:0] wr_addr;
  logic [8:0] wr_data;

  modport master (input in_word, in_valid, output in_ready, wr_en, wr_addr, wr_data);
  modport slave  (output in_word, in_valid, input in_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/instr_loader_ctr.sv
// Word counter with synchronous clear and a terminal-count compare.
module loader_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);

  // Count accepted words; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

  assign at_term = (count == term);

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: streams a reversed branch table followed by code words
// into a flat memory, holding the CPU for the duration of the load.
// Optional feature macro LOADER_CHECKSUM_EN adds a trailing XOR check word.
module instr_loader
  import instr_pkg::*;
#(
  parameter int D = D_DEF,
  parameter int B = B_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [D:0]    code_len,
  input  logic          abort,
  instr_loader_if.master bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam logic [D:0] MAX_LEN = {1'b1, {D{1'b0}}};
`ifdef LOADER_CHECKSUM_EN
  localparam state_t POST_LOAD = CHECK;
`else
  localparam state_t POST_LOAD = FINISH;
`endif

  state_t       state, state_nx;
  logic         acc, take;
  logic         start_acc, tbl_inc, code_inc, set_err;
  logic [D:0]   len_q;
  logic [B-1:0] tbl_cnt;
  logic         tbl_last;
  logic [D-1:0] code_cnt, code_term;
  logic         code_last;

  assign acc  = bus.in_valid & bus.in_ready;
  assign take = acc & ~abort;
  // len_q >= 1 whenever CODE is entered; 2**D wraps to all-ones, the right index.
  assign code_term = D'(len_q - 1'b1);

  loader_ctr #(.W(B)) u_tbl_ctr (
    .clk(clk), .rst_n(rst_n), .clr(start_acc), .inc(tbl_inc),
    .term({B{1'b1}}), .count(tbl_cnt), .at_term(tbl_last)
  );

  loader_ctr #(.W(D)) u_code_ctr (
    .clk(clk), .rst_n(rst_n), .clr(start_acc), .inc(code_inc),
    .term(code_term), .count(code_cnt), .at_term(code_last)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [8:0] csum;

  // Running XOR of every table and code word written this load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  csum <= '0;
    else if (start_acc)          csum <= '0;
    else if (tbl_inc | code_inc) csum <= csum ^ bus.in_word;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state, handshake and per-cycle control strobes.
  always_comb begin
    state_nx     = state;
    start_acc    = 1'b0;
    tbl_inc      = 1'b0;
    code_inc     = 1'b0;
    set_err      = 1'b0;
    bus.in_ready = 1'b0;
    done         = 1'b0;
    cpu_hold     = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nx  = TABLE;
        end
      end
      TABLE: begin
        bus.in_ready = 1'b1;
        if (take) begin
          tbl_inc = 1'b1;
          if (tbl_last) state_nx = (len_q == '0) ? POST_LOAD : CODE;
        end
      end
      CODE: begin
        bus.in_ready = 1'b1;
        if (take) begin
          code_inc = 1'b1;
          if (code_last) state_nx = POST_LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        bus.in_ready = 1'b1;
        if (take) begin
          if (bus.in_word == csum) state_nx = FINISH;
          else begin
            set_err  = 1'b1;
            state_nx = IDLE;
          end
        end
      end
`endif
      FINISH: begin
        done     = ~err & ~abort;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Abort overrides everything outside IDLE, including a same-cycle word.
    if (state != IDLE && abort) begin
      set_err  = 1'b1;
      state_nx = IDLE;
    end
  end

  // Registered write port, latched length and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      len_q       <= '0;
      err         <= 1'b0;
    end else begin
      bus.wr_en <= tbl_inc | code_inc;
      if (tbl_inc) begin
        bus.wr_addr <= {{(D+1-B){1'b0}}, ~tbl_cnt};
        bus.wr_data <= bus.in_word;
      end else if (code_inc) begin
        bus.wr_addr <= (D+1)'(code_addr(32'(code_cnt), B));
        bus.wr_data <= bus.in_word;
      end
      if (start_acc) begin
        len_q <= (code_len > MAX_LEN) ? MAX_LEN : code_len;
        err   <= (code_len > MAX_LEN);
      end else if (set_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table of directed loads plus random
// loads, all checked against a word-level model of the flat memory map.
`timescale 1ns/1ps
module tb_instr_loader;
  import instr_pkg::*;

  localparam int D    = D_DEF;
  localparam int B    = B_DEF;
  localparam int TW   = TABLE_WORDS;
  localparam int CMAX = 1 << D;

  logic       clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [D:0] code_len = '0;
  logic       cpu_hold, done, err;

  instr_loader_if #(.D(D)) bus();

  instr_loader #(.D(D), .B(B)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .code_len(code_len),
    .abort(abort), .bus(bus), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  typedef struct {
    string name; int len; int abort_at; int gap_at;
    bit bad_cs; bit busy_start; bit fixed;
    int exp_writes; bit exp_done; bit exp_err;
  } vec_t;

  int   checks = 0, errors = 0;
  wr_t  wq[$];
  int   done_cnt = 0, hold_lo = 0, to_cnt = 0;
  bit   in_load = 0;
  logic [8:0] tw[TW];
  logic [8:0] cw[$];
  vec_t vt[$];

  // Record every write strobe, done pulse and any hold drop during a load.
  always @(negedge clk) if (rst_n) begin
    if (bus.wr_en) wq.push_back('{addr: int'(bus.wr_addr), data: int'(bus.wr_data)});
    if (done) done_cnt++;
    if (in_load && !cpu_hold) hold_lo++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Outcome of a load from the rules: clamp, abort and checksum all flag err.
  function automatic void model(input int len, input int ab, input bit bad,
                                output int nw, output bit dn, output bit er);
    int  n;
    bit  cs_fail;
    bit  aborted;
    n       = (len > CMAX) ? CMAX : len;
    cs_fail = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    cs_fail = bad;
`endif
    aborted = (ab >= 0 && ab < n);
    er = (len > CMAX) || aborted || cs_fail;
    dn = !er;
    nw = TW + (aborted ? ab : n);
  endfunction

  task automatic addv(input string nm, input int len, input int ab, input int gap,
                      input bit bad, input bit busy, input bit fx,
                      input int nw, input bit dn, input bit er);
    vt.push_back('{name: nm, len: len, abort_at: ab, gap_at: gap, bad_cs: bad,
                   busy_start: busy, fixed: fx, exp_writes: nw, exp_done: dn, exp_err: er});
  endtask

  // Present one word (optionally with abort) and wait, bounded, for acceptance.
  task automatic push(input logic [8:0] w, input bit ab);
    int t = 0;
    bus.in_word = w; bus.in_valid = 1'b1; abort = ab;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin @(negedge clk); t++; end
    if (!bus.in_ready) to_cnt++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic run_load(input vec_t v);
    int n, m, bad;
    bit aborted;
    logic [8:0] cs;
    wr_t exp[$];
    n = (v.len > CMAX) ? CMAX : v.len;
    for (int k = 0; k < TW; k++) tw[k] = v.fixed ? 9'(k) : 9'($urandom);
    cw.delete();
    for (int j = 0; j < n; j++) cw.push_back(v.fixed ? 9'(32'h101 + j) : 9'($urandom));
    wq.delete(); done_cnt = 0; hold_lo = 0; to_cnt = 0; aborted = 0;
    start = 1'b1; code_len = (D+1)'(v.len);
    @(posedge clk); #1;
    start = 1'b0; in_load = 1'b1;
    for (int k = 0; k < TW; k++) begin
      if (v.busy_start && k == 10) begin start = 1'b1; code_len = 7; end
      push(tw[k], 1'b0);
      start = 1'b0;
    end
    for (int j = 0; j < n && !aborted; j++) begin
      if (j == v.gap_at) begin
        int n0;
        @(negedge clk); #1; n0 = wq.size();
        repeat (5) @(negedge clk);
        #1; chk({v.name, ".gap_no_write"}, wq.size(), n0);
        @(posedge clk); #1;
      end
      push(cw[j], j == v.abort_at);
      if (j == v.abort_at) aborted = 1;
    end
`ifdef LOADER_CHECKSUM_EN
    if (!aborted) begin
      cs = '0;
      foreach (tw[k]) cs ^= tw[k];
      foreach (cw[j]) cs ^= cw[j];
      if (v.bad_cs) cs ^= 9'h001;
      push(cs, 1'b0);
    end
`endif
    in_load = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    m = aborted ? v.abort_at : n;
    for (int k = 0; k < TW; k++) exp.push_back('{addr: TW - 1 - k, data: int'(tw[k])});
    for (int j = 0; j < m; j++) exp.push_back('{addr: TW + j, data: int'(cw[j])});
    bad = 0;
    for (int i = 0; i < wq.size() && i < exp.size(); i++)
      if (wq[i].addr != exp[i].addr || wq[i].data != exp[i].data) bad++;
    chk({v.name, ".writes"},      wq.size(), v.exp_writes);
    chk({v.name, ".wr_seq_bad"},  bad, 0);
    chk({v.name, ".done_pulses"}, done_cnt, v.exp_done ? 1 : 0);
    chk({v.name, ".err"},         err, v.exp_err);
    chk({v.name, ".hold_after"},  cpu_hold, 0);
    chk({v.name, ".hold_drops"},  hold_lo, 0);
    chk({v.name, ".ready_to"},    to_cnt, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int nw; bit dn, er;
    int len, ab, gap; bit bad;
    bus.in_word = '0; bus.in_valid = 1'b0;

    // Directed table: branch/empty/gap/abort/busy-start/checksum/clamp.
    addv("branch",      3,   -1, -1, 0, 0, 1, 35,   1, 0);
    addv("empty",       0,   -1, -1, 0, 0, 0, 32,   1, 0);
    addv("gap",         20,  -1,  7, 0, 0, 0, 52,   1, 0);
    addv("abort10",     20,   9, -1, 0, 0, 0, 41,   0, 1);
    addv("after_abort", 2,   -1, -1, 0, 0, 0, 34,   1, 0);
    addv("busy_start",  2,   -1, -1, 0, 1, 0, 34,   1, 0);
    addv("cs_good",     4,   -1, -1, 0, 0, 0, 36,   1, 0);
`ifdef LOADER_CHECKSUM_EN
    addv("cs_bad",      4,   -1, -1, 1, 0, 0, 36,   0, 1);
`else
    addv("cs_bad",      4,   -1, -1, 1, 0, 0, 36,   1, 0);
`endif
    addv("clamp",       4097, -1, -1, 0, 0, 0, 4128, 0, 1);
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(0, 40);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      gap = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : -1;
      bad = 1'($urandom_range(0, 1));
      model(len, ab, bad, nw, dn, er);
      addv($sformatf("rnd%0d", r), len, ab, gap, bad, 0, 0, nw, dn, er);
    end

    // Outputs while held in reset.
    #2;
    chk("rst_outputs", {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, cpu_hold, done, err}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i]) run_load(vt[i]);

    // Reset dropped mid-TABLE with a write in flight and err already set.
    wq.delete(); done_cnt = 0;
    start = 1'b1; code_len = 4097;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 6; k++) push(9'(k + 100), 1'b0);
    chk("mid_rst.err_before", err, 1);
    chk("mid_rst.wr_before", bus.wr_en, 1);
    rst_n = 1'b0; #1;
    chk("mid_rst.outputs", {bus.in_ready, bus.wr_en, bus.wr_addr, bus.wr_data, cpu_hold, done, err}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("mid_rst.idle_hold", cpu_hold, 0);
    chk("mid_rst.no_done", done_cnt, 0);
    @(posedge clk); #1;

    // A clean load after the reset still works.
    model(1, -1, 0, nw, dn, er);
    addv("post_rst", 1, -1, -1, 0, 0, 0, nw, dn, er);
    run_load(vt[vt.size() - 1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter D, default 12: program-counter width; the code region holds 2**D words.
REQ-002 Parameter B, default 5: branch-table index width; the table holds 2**B words.
REQ-003 Port clk, input, 1: single clock, rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port start, input, 1: one-cycle pulse that begins a load.
REQ-006 Port code_len, input, D+1: number of code words, sampled when start is accepted.
REQ-007 Port abort, input, 1: terminates the load and flags an error.
REQ-008 Port in_word, input, 9: incoming machine-code or branch-table word.
REQ-009 Port in_valid, input, 1: in_word is valid.
REQ-010 Port in_ready, output, 1: loader accepts in_word this cycle.
REQ-011 Port wr_en, output, 1: memory write strobe.
REQ-012 Port wr_addr, output, D+1: flat memory address (table region first, then code region).
REQ-013 Port wr_data, output, 9: word to write.
REQ-014 Port cpu_hold, output, 1: holds the CPU while the load is in progress.
REQ-015 Port done, output, 1: one-cycle pulse on successful completion.
REQ-016 Port err, output, 1: sticky error flag, cleared by the next accepted start.

Function
REQ-017 States SHALL be IDLE, TABLE, CODE, CHECK and FINISH.
REQ-018 A word is accepted only when in_valid and in_ready are both high; in_ready SHALL be high only in TABLE, CODE and CHECK.
REQ-019 IDLE->TABLE on start: clear the count, latch code_len and clear err.
- start SHALL be ignored in any state other than IDLE.
REQ-020 TABLE: the k-th accepted word (k = 0..2**B-1) is written to address 2**B-1-k, so the stream is stored in reverse order.
- After 2**B words: go to CODE, or skip to CHECK/FINISH if code_len = 0.
REQ-021 CODE: the j-th accepted word is written to address 2**B + j.
- After code_len words: go to CHECK (macro defined) or FINISH.
REQ-022 code_len > 2**D SHALL be clamped to 2**D.
- err SHALL be set at start-accept.
- The load proceeds with the clamped length.
REQ-023 Write latency SHALL be one cycle: wr_en, wr_addr and wr_data are registered.
- They appear the cycle after acceptance.
- wr_en is high for exactly one cycle per accepted table/code word.
REQ-024 FINISH SHALL pulse done for one cycle, then return to IDLE.
- FINISH is a one-cycle state.
- No done pulse is issued if err is set.
REQ-025 cpu_hold SHALL be high in every state except IDLE.
- It is high from the cycle after start is accepted through the FINISH cycle inclusive.
REQ-026 abort in any non-IDLE state SHALL:
- set err;
- return to IDLE next cycle with no done pulse;
- suppress any write for a word accepted in that same cycle.
REQ-027 in_valid held low SHALL stall the count indefinitely with no timeout.

Reset
REQ-028 While rst_n is low, the following SHALL be forced:
- state=IDLE
- in_ready=0, wr_en=0, wr_addr=0, wr_data=0
- cpu_hold=0, done=0, err=0
- all counters and the checksum cleared
REQ-029 Reset mid-load SHALL abandon the load; memory contents are undefined and no done pulse is issued.

Configuration
REQ-030 Macro LOADER_CHECKSUM_EN defined:
- a running XOR of all accepted table and code words is kept;
- CHECK accepts one extra word;
- on a match, go to FINISH;
- on a mismatch, set err and return to IDLE;
- the check word is never written to memory.
REQ-031 Macro undefined: the CHECK state and XOR logic are absent, and the last word goes directly to FINISH.

Structure
REQ-032 Package instr_pkg SHALL hold:
- the defaults for D and B;
- the state enum;
- the constant TABLE_WORDS = 2**B;
- an address-map function returning the flat address of a code word.
REQ-033 Sub-module loader_ctr (a counter with a terminal-count compare) SHALL be used for the table and code word counts.

Verification
REQ-034 Branch table: start with code_len=3, stream 32 table words 0..31 then code 0x101,0x102,0x103 -> table words land at addresses 31..0 in reverse, code at 32..34, one done pulse, cpu_hold high for the whole load.
REQ-035 Empty program: code_len=0 -> exactly 32 writes, then done (after the check word if the macro is defined).
REQ-036 Backpressure gaps: drop in_valid for 5 cycles mid-CODE -> no writes during the gap, addresses continue contiguously.
REQ-037 Abort: assert abort on the 10th code word -> err=1, no done, that word is not written, state returns to IDLE, cpu_hold falls.
REQ-038 Checksum (macro defined): a correct XOR word -> done; the XOR word ^ 9'h001 -> err=1, no done.
REQ-039 Reset and start rules: drop rst_n low mid-TABLE -> all outputs 0 immediately; a start while busy -> ignored; code_len=4097 -> err=1 and exactly 4096 code writes.
